// File: rtl/jstepper_if.sv
// jcscpu step/phase sequencer bundle: run controls in, step/phase strobes out.
interface jstepper_if #(
   parameter int NSTEPS = 7
);
   logic              wrun;
   logic              wsingle;
   logic              wsclr;
   logic [NSTEPS-1:0] bsteps;
   logic [1:0]        bphase;
   logic              wclke;
   logic              wclks;
   logic              wlast;

   modport master (
      output wrun, wsingle, wsclr,
      input  bsteps, bphase, wclke, wclks, wlast
   );

   modport slave (
      input  wrun, wsingle, wsclr,
      output bsteps, bphase, wclke, wclks, wlast
   );
endinterface

// File: rtl/jstepper.sv
// jcscpu step/phase sequencer: four clock phases per step, one-hot step vector,
// gated enable/set strobes decoded purely from registered state.
module jstepper #(
   parameter int NSTEPS = 7
) (
   input logic        wclk,
   input logic        wrst,
   jstepper_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ONE  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        phase_q;
   logic [NSTEPS-1:0] step_q;
   logic              active;
   logic              bnd;

   assign active = (state_q != IDLE);
   assign bnd    = active && (phase_q == 2'd3);

   // State register; phase and step ride along with it
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q <= IDLE;
         phase_q <= 2'd0;
         step_q  <= {{(NSTEPS-1){1'b0}}, 1'b1};
      end else begin
         state_q <= state_d;
         phase_q <= active ? phase_q + 2'd1 : 2'd0;
         if (bnd) begin
            if (bus.wsclr || step_q[NSTEPS-1])
               step_q <= {{(NSTEPS-1){1'b0}}, 1'b1};
            else
               step_q <= {step_q[NSTEPS-2:0], 1'b0};
         end
      end
   end

   // A step, once started, always runs its four phases to completion
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.wrun)
               state_d = RUN;
            else if (bus.wsingle)
               state_d = ONE;
         end
         RUN: begin
            if (bnd && !bus.wrun)
               state_d = IDLE;
         end
         ONE: begin
            if (bnd)
               state_d = bus.wrun ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.bsteps = step_q;
      bus.bphase = phase_q;
      bus.wclke  = active && (phase_q != 2'd3);
      bus.wclks  = active && (phase_q == 2'd1);
      bus.wlast  = step_q[NSTEPS-1];
   end
endmodule
